// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer:
// MDU op codes, FSM state type and an op-class helper.
package mdu_seq_pkg;

    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MTHI  = 5'd5;
    localparam logic [4:0] OP_MTLO  = 5'd6;
    localparam logic [4:0] OP_MFHI  = 5'd7;
    localparam logic [4:0] OP_MFLO  = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq.sv
// HI/LO owner for the E stage: computes mult/div results at acceptance,
// then holds them pending for a fixed busy period before committing.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  MDU_op,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic        int_exc_req,
    output logic        busy,
    output logic        real_busy,
    output logic [31:0] MDU_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  state_dbg
);

    mdu_state_e  state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_commit;

    logic        accept;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] q_s, r_s, q_u, r_u;

    assign accept    = start && !int_exc_req && (state == ST_IDLE);
    assign real_busy = busy || (start && is_long_op(MDU_op) && !int_exc_req);
    assign state_dbg = state;

    // Divisor is forced non-zero so the dividers never see /0; the
    // zero case is suppressed at commit instead.
    always_comb begin
        divisor = (D2 == 32'd0) ? 32'd1 : D2;
        prod_s  = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
        prod_u  = {32'd0, D1} * {32'd0, D2};
        if (D1 == 32'h8000_0000 && D2 == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(D1) / $signed(divisor);
            r_s = $signed(D1) % $signed(divisor);
        end
        q_u = D1 / divisor;
        r_u = D1 % divisor;
    end

    always_comb begin
        MDU_out = 32'd0;
        if (MDU_op == OP_MFHI)      MDU_out = hi;
        else if (MDU_op == OP_MFLO) MDU_out = lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            busy        <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            pend_hi     <= 32'd0;
            pend_lo     <= 32'd0;
            pend_commit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (MDU_op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi     <= (MDU_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                                pend_lo     <= (MDU_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                                pend_commit <= 1'b1;
                                cnt         <= 4'(MUL_CYCLES);
                                busy        <= 1'b1;
                                state       <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi     <= (MDU_op == OP_DIV) ? r_s : r_u;
                                pend_lo     <= (MDU_op == OP_DIV) ? q_s : q_u;
                                pend_commit <= (D2 != 32'd0);
                                cnt         <= 4'(DIV_CYCLES);
                                busy        <= 1'b1;
                                state       <= ST_DIV;
                            end
                            OP_MTHI: hi <= D1;
                            OP_MTLO: lo <= D1;
                            default: ;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    // New starts are ignored here; interrupts never abort.
                    if (cnt == 4'd1) begin
                        if (pend_commit) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= 4'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
